// File: rtl/satd_gen_core.sv
// -----------------------------------------------------------------------------
// satd_gen_core
//
// Sequential minimum-SATD search over NUM_CAND flat candidate predictors for
// one 4x4 block. Each clock evaluates one candidate through a full 4x4
// Hadamard transform of the residual. A running minimum keeps the first
// (lowest-index) candidate that reaches the smallest SATD.
//
// Parameters
//   NUM_CAND   number of candidates, legal range 2..16
//
// Ports
//   clk        single clock, rising edge
//   rst1       synchronous active-high reset
//   half_quat  NUM_CAND x 8-bit unsigned candidate values, element k = cand k
//   cur_pix    16 x 8-bit unsigned current block, index = 4*row + col
//   best       index of the minimum-SATD candidate (registered)
//   best_satd  SATD of candidate best (registered)
//   done       evaluation complete, best/best_satd valid (registered)
//
// Build option
//   SATD_HALVE_EN  when defined, the candidate SATD is (sum |T|) >> 1
//
// State table
//   IDLE | reset held; the first edge after release evaluates candidate 0
//   RUN  | evaluating candidate idx (1..NUM_CAND-1)
//   DONE | terminal; outputs frozen until the next reset
// -----------------------------------------------------------------------------
module satd_gen_core #(
    parameter int NUM_CAND = 9
) (
    input  logic                     clk,
    input  logic                     rst1,
    input  logic [NUM_CAND-1:0][7:0] half_quat,
    input  logic [15:0][7:0]         cur_pix,
    output logic [3:0]               best,
    output logic [15:0]              best_satd,
    output logic                     done
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_CAND - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  idx;
    logic [15:0] min_satd;
    logic [3:0]  min_idx;

    logic [7:0]         hq_sel;
    logic signed [8:0]  diff;
    logic signed [12:0] r [4][4];
    logic signed [12:0] m [4][4];
    logic signed [12:0] t [4][4];
    logic signed [12:0] mag;
    logic [15:0]        sum_abs;
    logic [15:0]        cand_satd;
    logic               better;
    logic [15:0]        next_min;
    logic [3:0]         next_idx;

    // Row k of H dotted with (a0, a1, a2, a3). H is symmetric, so the same
    // helper serves both the column pass (H*R) and the row pass ((H*R)*H).
    function automatic logic signed [12:0] hrow(
        input int                 k,
        input logic signed [12:0] a0,
        input logic signed [12:0] a1,
        input logic signed [12:0] a2,
        input logic signed [12:0] a3
    );
        logic signed [12:0] res;
        case (k)
            0:       res = a0 + a1 + a2 + a3;
            1:       res = a0 - a1 + a2 - a3;
            2:       res = a0 + a1 - a2 - a3;
            default: res = a0 - a1 - a2 + a3;
        endcase
        return res;
    endfunction

    always_comb begin
        hq_sel    = half_quat[idx];
        diff      = '0;
        mag       = '0;
        sum_abs   = '0;
        cand_satd = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                r[i][j] = '0;
                m[i][j] = '0;
                t[i][j] = '0;
            end
        end

        // 9-bit wrap of the unsigned difference is the exact two's complement
        // residual in -255..255; sign-extend into the 13-bit datapath.
        for (int i = 0; i < 16; i++) begin
            diff          = 9'({1'b0, cur_pix[i]}) - 9'({1'b0, hq_sel});
            r[i/4][i%4]   = 13'(diff);
        end

        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                m[k][c] = hrow(k, r[0][c], r[1][c], r[2][c], r[3][c]);
            end
        end

        for (int rr = 0; rr < 4; rr++) begin
            for (int k = 0; k < 4; k++) begin
                t[rr][k] = hrow(k, m[rr][0], m[rr][1], m[rr][2], m[rr][3]);
            end
        end

        // |T| <= 4080, so the 16-entry sum is at most 65280 and fits 16 bits.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                mag     = (t[i][j] < 0) ? -t[i][j] : t[i][j];
                sum_abs = sum_abs + 16'($unsigned(mag));
            end
        end

`ifdef SATD_HALVE_EN
        cand_satd = sum_abs >> 1;
`else
        cand_satd = sum_abs;
`endif
    end

    // Strict less-than keeps the earliest candidate on ties.
    assign better   = (cand_satd < min_satd);
    assign next_min = better ? cand_satd : min_satd;
    assign next_idx = better ? idx : min_idx;

    always_ff @(posedge clk) begin
        if (rst1) begin
            state     <= IDLE;
            idx       <= '0;
            min_satd  <= 16'hFFFF;
            min_idx   <= '0;
            best      <= '0;
            best_satd <= '0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    min_satd <= next_min;
                    min_idx  <= next_idx;
                    if (idx == LAST_IDX) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        best      <= next_idx;
                        best_satd <= next_min;
                    end else begin
                        state <= RUN;
                        idx   <= idx + 4'd1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_satd_gen_core.sv
module tb_satd_gen_core;

    localparam int N = 9;

    logic               clk = 1'b0;
    logic               rst1 = 1'b1;
    logic [N-1:0][7:0]  half_quat;
    logic [15:0][7:0]   cur_pix;
    logic [3:0]         best;
    logic [15:0]        best_satd;
    logic               done;

    typedef struct {
        int    b;
        int    s;
        int    lat;
        string name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic done_q = 1'b0;

    satd_gen_core #(.NUM_CAND(N)) dut (
        .clk       (clk),
        .rst1      (rst1),
        .half_quat (half_quat),
        .cur_pix   (cur_pix),
        .best      (best),
        .best_satd (best_satd),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Edges since reset release.
    always @(posedge clk) begin
        if (rst1) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    function automatic int sc(input int raw);
`ifdef SATD_HALVE_EN
        return raw >> 1;
`else
        return raw;
`endif
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Monitor: pop one expectation on every rising edge of done.
    always @(negedge clk) begin
        exp_t e;
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = sb.pop_front();
                check({e.name, "_best"}, int'(best), e.b);
                check({e.name, "_satd"}, int'(best_satd), e.s);
                check({e.name, "_latency"}, cyc, e.lat);
            end
        end
        done_q = done;
    end

    task automatic run_case(input string nm,
                            input logic [N-1:0][7:0] hq,
                            input logic [15:0][7:0] cp,
                            input int eb, input int es, input bit mid_rst);
        exp_t e;
        @(negedge clk);
        half_quat = hq;
        cur_pix   = cp;
        rst1      = 1'b1;
        @(negedge clk);
        check({nm, "_rst_done"}, int'(done), 0);
        check({nm, "_rst_best"}, int'(best), 0);
        check({nm, "_rst_satd"}, int'(best_satd), 0);
        e.b = eb; e.s = es; e.lat = N; e.name = nm;
        sb.push_back(e);
        rst1 = 1'b0;
        if (mid_rst) begin
            repeat (3) @(negedge clk);
            rst1 = 1'b1;
            @(negedge clk);
            check({nm, "_midrst_done"}, int'(done), 0);
            rst1 = 1'b0;
        end
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", nm);
            sb.delete();
        end
    endtask

    initial begin
        logic [N-1:0][7:0] h;
        logic [15:0][7:0]  c;
        int v[N];

        half_quat = '0;
        cur_pix   = '0;

        // Exact match at candidate 4.
        v = '{50, 60, 70, 80, 100, 120, 130, 140, 150};
        for (int k = 0; k < N; k++) h[k] = 8'(v[k]);
        for (int i = 0; i < 16; i++) c[i] = 8'd100;
        run_case("ordered", h, c, 4, 0, 1'b0);

        // Outputs frozen after done while inputs wander.
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) half_quat[k] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 16; i++) cur_pix[i] = 8'($urandom_range(0, 255));
            @(negedge clk);
            check("hold_done", int'(done), 1);
            check("hold_best", int'(best), 4);
            check("hold_satd", int'(best_satd), 0);
        end

        // All candidates equal: flat residual 50 -> 16*50.
        for (int k = 0; k < N; k++) h[k] = 8'd50;
        run_case("flat50", h, c, 0, sc(800), 1'b0);

        // Only the last candidate matches.
        for (int k = 0; k < N; k++) h[k] = 8'd0;
        h[N-1] = 8'd200;
        for (int i = 0; i < 16; i++) c[i] = 8'd200;
        run_case("last", h, c, 8, 0, 1'b0);
        run_case("midrst", h, c, 8, 0, 1'b1);

        // |d| = 1 tie between candidates 2 and 3.
        v = '{12, 8, 9, 11, 40, 40, 40, 40, 40};
        for (int k = 0; k < N; k++) h[k] = 8'(v[k]);
        for (int i = 0; i < 16; i++) c[i] = 8'd10;
        run_case("tie", h, c, 2, sc(16), 1'b0);

        // Non-flat residual: SATDs 224,160,1696,128,160,128,1728,1728,1728.
        v = '{108, 104, 200, 100, 104, 100, 0, 0, 0};
        for (int k = 0; k < N; k++) h[k] = 8'(v[k]);
        for (int i = 0; i < 16; i++) c[i] = 8'd100;
        c[0] = 8'd108;
        c[1] = 8'd108;
        run_case("pattern", h, c, 3, sc(128), 1'b0);

        // Fully negative residual -255 everywhere.
        for (int k = 0; k < N; k++) h[k] = 8'd255;
        for (int i = 0; i < 16; i++) c[i] = 8'd0;
        run_case("neg", h, c, 0, sc(4080), 1'b0);

        // Large positive residual with a near match at candidate 6.
        for (int k = 0; k < N; k++) h[k] = 8'd0;
        h[6] = 8'd254;
        for (int i = 0; i < 16; i++) c[i] = 8'd255;
        run_case("near", h, c, 6, sc(16), 1'b0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/satd_gen_core.md
SATD_GEN_CORE -- requirements
Module: satd_gen_core

Interface
REQ-001 SHALL have parameter NUM_CAND, default 9: number of candidates evaluated (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst1, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port half_quat, input, NUM_CAND x 8 bits: unsigned candidate predictor values; element k is candidate k.
REQ-005 SHALL have port cur_pix, input, 16 x 8 bits: unsigned current 4x4 block, raster order (index = 4*row + col).
REQ-006 SHALL have port best, output, 4 bits: index of the minimum-SATD candidate.
REQ-007 SHALL have port best_satd, output, 16 bits: SATD of candidate best.
REQ-008 SHALL have port done, output, 1 bit: evaluation complete; best and best_satd valid.

Function
REQ-009 SHALL evaluate one candidate per clock, in order k = 0..NUM_CAND-1, starting on the first rising edge with rst1 low.
REQ-010 SHALL compute the residual for candidate k as r[i] = cur_pix[i] - half_quat[k], 9-bit signed, i = 0..15.
REQ-011 SHALL form T = H*R*H, where R is the 4x4 residual matrix and H rows are [1,1,1,1], [1,-1,1,-1], [1,1,-1,-1], [1,-1,-1,1].
REQ-012 SHALL carry T in 13-bit signed arithmetic, with no overflow or saturation.
REQ-013 SHALL define SATD as the sum of the 16 values |T|, kept to 16 bits unsigned, with any scaling per REQ-025..REQ-026.
REQ-014 SHALL update the running minimum only when the candidate SATD is strictly less than the stored minimum.
REQ-015 SHALL therefore report the lowest index on ties; if all candidates are equal, best = 0.
REQ-016 SHALL assert done on the edge that registers candidate NUM_CAND-1 (NUM_CAND edges after reset release), with best and best_satd final on that same edge.
REQ-017 SHALL hold done, best and best_satd stable once done = 1, until the next reset.
REQ-018 SHALL sample the inputs for candidate k in the cycle it is evaluated; the surrounding controller keeps half_quat and cur_pix stable from reset release until done.
REQ-019 SHALL use a state machine with states IDLE (reset held), RUN (index 0..NUM_CAND-1) and DONE (terminal), with transitions IDLE->RUN on reset release, RUN->DONE after the last candidate, and DONE->DONE.
REQ-020 SHALL contain no combinational path from input to output; all outputs are registered.

Reset
REQ-021 SHALL, with rst1 high at a clock edge, clear done to 0, best to 0 and best_satd to 0, set the candidate index to 0 and set the running minimum to 0xFFFF.
REQ-022 SHALL abandon the evaluation on rst1 asserted mid-RUN; after release it restarts at candidate 0, with done high NUM_CAND edges after release.
REQ-023 SHALL clear done on the next edge when rst1 is asserted while in DONE.
REQ-024 SHALL give rst1 priority over all other activity in the same cycle.

Configuration
REQ-025 SHALL, with macro SATD_HALVE_EN defined, report SATD as (sum of |T|) >> 1, truncated; best_satd carries the halved value.
REQ-026 SHALL, with SATD_HALVE_EN undefined, use the raw sum; ties created by halving resolve per REQ-015.

Verification
REQ-027 SHALL pass: cur_pix all 100, half_quat = {50,60,70,80,100,120,130,140,150}, rst1 1->0 -> best = 4, best_satd = 0, done high exactly 9 edges after release.
REQ-028 SHALL pass: cur_pix all 100, half_quat all 50 -> best = 0, best_satd = 800 without SATD_HALVE_EN and 400 with it.
REQ-029 SHALL pass: cur_pix all 200, half_quat[8] = 200, others 0 -> best = 8, best_satd = 0.
REQ-030 SHALL pass: rst1 pulsed high for 1 cycle at the 4th RUN edge -> done stays 0, then rises 9 edges after the pulse ends, with correct best.
REQ-031 SHALL pass: after done, 20 further cycles with inputs changed -> done, best and best_satd unchanged.
REQ-032 SHALL pass: cur_pix all 10, half_quat = {12,8,9,11,...} -> tie between candidates 2 and 3 (|d| = 1) resolves to best = 2.
